// File: rtl/vga_fb_pkg.sv
// Shared constants, size helpers and FSM encoding for the frame buffer reader.
// Sizes are derived from the display geometry and the upscale factor.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        FB_IDLE,
        FB_ACTIVE,
        FB_DONE
    } fb_state_t;

    localparam int MAX_SCALE_LOG2  = 2;
    localparam int MAX_MEM_LATENCY = 3;

    function automatic bit scale_log2_legal(input int scale_log2);
        return (scale_log2 >= 0) && (scale_log2 <= MAX_SCALE_LOG2);
    endfunction

    function automatic bit mem_latency_legal(input int mem_latency);
        return (mem_latency >= 1) && (mem_latency <= MAX_MEM_LATENCY);
    endfunction

    function automatic int src_w(input int h_active, input int scale_log2);
        return h_active >> scale_log2;
    endfunction

    function automatic int src_h(input int v_active, input int scale_log2);
        return v_active >> scale_log2;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_width(input int h_active, input int v_active, input int scale_log2);
        return cnt_width(src_w(h_active, scale_log2) * src_h(v_active, scale_log2));
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Display-raster counters that turn (h_cnt, v_cnt) into source-image addresses,
// replicating pixels and lines by 2**SCALE_LOG2.
module fb_addr_gen
    import vga_fb_pkg::*;
#(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int SCALE_LOG2 = 0,
    parameter int ADDR_WIDTH = addr_width(H_ACTIVE, V_ACTIVE, SCALE_LOG2)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  restart,
    input  logic                  step,
    output logic [ADDR_WIDTH-1:0] pix_addr,
    output logic                  last_pixel,
    output logic                  at_origin
);

    localparam int HW = cnt_width(H_ACTIVE);
    localparam int VW = cnt_width(V_ACTIVE);
    localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] REP_MASK = VW'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_STRIDE = ADDR_WIDTH'(src_w(H_ACTIVE, SCALE_LOG2));

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic [HW-1:0]         cur_h;
    logic [VW-1:0]         cur_v;
    logic [VW-1:0]         v_next;
    logic [ADDR_WIDTH-1:0] cur_base;

    // A restart takes effect in the same cycle, so a pixel taken alongside it reads address 0.
    always_comb begin
        cur_h    = h_cnt;
        cur_v    = v_cnt;
        cur_base = line_base;
        if (restart) begin
            cur_h    = '0;
            cur_v    = '0;
            cur_base = '0;
        end
    end

    assign v_next     = cur_v + VW'(1);
    assign pix_addr   = cur_base + ADDR_WIDTH'(cur_h >> SCALE_LOG2);
    assign last_pixel = (cur_h == H_LAST) && (cur_v == V_LAST);
    assign at_origin  = (h_cnt == '0) && (v_cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
        end else if (step) begin
            if (last_pixel) begin
                h_cnt     <= '0;
                v_cnt     <= '0;
                line_base <= '0;
            end else if (cur_h == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= v_next;
                // Only move to the next source line once every replica of this one is shown.
                line_base <= ((v_next & REP_MASK) == '0) ? cur_base + LINE_STRIDE : cur_base;
            end else begin
                h_cnt     <= cur_h + HW'(1);
                v_cnt     <= cur_v;
                line_base <= cur_base;
            end
        end else if (restart) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            line_base <= '0;
        end
    end

endmodule

// File: rtl/framebuffer_reader.sv
// Frame buffer read controller: issues one RAM read per active pixel and returns
// the pixel a fixed MEM_LATENCY+2 cycles later, blanking everything else.
module framebuffer_reader
    import vga_fb_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int CHANNELS    = 3,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SCALE_LOG2  = 0,
    parameter int MEM_LATENCY = 1,
    parameter int BLANK_VALUE = 0,
    parameter int ADDR_WIDTH  = addr_width(H_ACTIVE, V_ACTIVE, SCALE_LOG2)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           video_on,
    output logic                           mem_rd_en,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic [CHANNELS*DATA_WIDTH-1:0] mem_rd_data,
    output logic [CHANNELS*DATA_WIDTH-1:0] pixel_data,
    output logic                           pixel_valid,
    output logic                           frame_done,
    output logic                           sync_err,
    input  logic                           err_clear
);

    localparam int PIX_W = CHANNELS * DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] BLANK_CH  = DATA_WIDTH'(BLANK_VALUE);
    localparam logic [PIX_W-1:0]      BLANK_PIX = {CHANNELS{BLANK_CH}};

    if (!scale_log2_legal(SCALE_LOG2)) begin : g_bad_scale
        $error("framebuffer_reader: SCALE_LOG2 must be 0, 1 or 2");
    end
    if (!mem_latency_legal(MEM_LATENCY)) begin : g_bad_latency
        $error("framebuffer_reader: MEM_LATENCY must be 1, 2 or 3");
    end

    fb_state_t             state;
    logic                  take_pixel;
    logic                  err_event;
    logic                  last_pixel;
    logic                  at_origin;
    logic [ADDR_WIDTH-1:0] pix_addr;
    logic [MEM_LATENCY-1:0] valid_pipe;

    // frame_start is honoured before video_on, so it can open a frame and read its first pixel at once.
    assign take_pixel = video_on && (frame_start || (state == FB_ACTIVE));
    assign err_event  = (frame_start && (state == FB_ACTIVE) && !at_origin)
                     || (video_on && !frame_start && (state == FB_DONE));

    fb_addr_gen #(
        .H_ACTIVE   (H_ACTIVE),
        .V_ACTIVE   (V_ACTIVE),
        .SCALE_LOG2 (SCALE_LOG2),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clock      (clock),
        .reset      (reset),
        .restart    (frame_start),
        .step       (take_pixel),
        .pix_addr   (pix_addr),
        .last_pixel (last_pixel),
        .at_origin  (at_origin)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= FB_IDLE;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            mem_rd_en  <= take_pixel;
            frame_done <= take_pixel && last_pixel;
            if (take_pixel) begin
                mem_addr <= pix_addr;
            end
            // A fresh error outranks a clear arriving in the same cycle.
            if (err_event) begin
                sync_err <= 1'b1;
            end else if (err_clear) begin
                sync_err <= 1'b0;
            end
            case (state)
                FB_IDLE, FB_DONE: begin
                    if (frame_start) begin
                        state <= (take_pixel && last_pixel) ? FB_DONE : FB_ACTIVE;
                    end
                end
                FB_ACTIVE: begin
                    if (take_pixel && last_pixel) begin
                        state <= FB_DONE;
                    end
                end
                default: state <= FB_IDLE;
            endcase
        end
    end

    // valid_pipe tracks each read until its data is on mem_rd_data; the output register adds one more stage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_pipe  <= '0;
            pixel_valid <= 1'b0;
            pixel_data  <= BLANK_PIX;
        end else begin
            valid_pipe[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                valid_pipe[i] <= valid_pipe[i-1];
            end
            pixel_valid <= valid_pipe[MEM_LATENCY-1];
            pixel_data  <= valid_pipe[MEM_LATENCY-1] ? mem_rd_data : BLANK_PIX;
        end
    end

endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench driving an unscaled and a 2x-upscaled reader (8x4 display) from shared timing inputs,
// with a raster model feeding a scoreboard of expected reads, pixels and frame_done pulses.
module tb_framebuffer_reader;

    localparam int PW = 24;
    localparam logic [PW-1:0] BLANK0 = 24'h000000;
    localparam logic [PW-1:0] BLANK1 = 24'h111111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic frame_start = 1'b0;
    logic video_on = 1'b0;
    logic err_clear = 1'b0;

    logic          mem_rd_en0, mem_rd_en1;
    logic [4:0]    mem_addr0;
    logic [2:0]    mem_addr1;
    logic [PW-1:0] mem_rd_data0, mem_rd_data1;
    logic [PW-1:0] pixel_data0, pixel_data1;
    logic          pixel_valid0, pixel_valid1;
    logic          frame_done0, frame_done1;
    logic          sync_err0, sync_err1;

    always #5 clock = ~clock;

    framebuffer_reader #(
        .DATA_WIDTH(8), .CHANNELS(3), .H_ACTIVE(8), .V_ACTIVE(4),
        .SCALE_LOG2(0), .MEM_LATENCY(1), .BLANK_VALUE(0)
    ) dut0 (
        .clock(clock), .reset(reset), .frame_start(frame_start), .video_on(video_on),
        .mem_rd_en(mem_rd_en0), .mem_addr(mem_addr0), .mem_rd_data(mem_rd_data0),
        .pixel_data(pixel_data0), .pixel_valid(pixel_valid0), .frame_done(frame_done0),
        .sync_err(sync_err0), .err_clear(err_clear)
    );

    framebuffer_reader #(
        .DATA_WIDTH(8), .CHANNELS(3), .H_ACTIVE(8), .V_ACTIVE(4),
        .SCALE_LOG2(1), .MEM_LATENCY(1), .BLANK_VALUE(8'h11)
    ) dut1 (
        .clock(clock), .reset(reset), .frame_start(frame_start), .video_on(video_on),
        .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1), .mem_rd_data(mem_rd_data1),
        .pixel_data(pixel_data1), .pixel_valid(pixel_valid1), .frame_done(frame_done1),
        .sync_err(sync_err1), .err_clear(err_clear)
    );

    function automatic logic [PW-1:0] ram_word(input int a);
        logic [7:0] c0, c1, c2;
        c0 = 8'(a + 32);
        c1 = 8'(a ^ 8'h5A);
        c2 = 8'(a * 3 + 1);
        return {c2, c1, c0};
    endfunction

    // One-cycle RAM models; junk on the bus when not reading exercises the blanking.
    always @(posedge clock) begin
        mem_rd_data0 <= mem_rd_en0 ? ram_word(int'(mem_addr0)) : 24'hEEEEEE;
        mem_rd_data1 <= mem_rd_en1 ? ram_word(int'(mem_addr1)) : 24'hEEEEEE;
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef enum {M_IDLE, M_ACTIVE, M_DONE} mstate_t;
    typedef struct { int e; int a0; int a1; } rd_item_t;
    typedef struct { int e; logic [PW-1:0] p0; logic [PW-1:0] p1; } px_item_t;
    typedef struct {
        int   pre;
        logic fs;
        logic von;
        logic clr;
        logic exp_rd;
        int   exp_a0;
        int   exp_a1;
        logic exp_err;
    } vec_t;

    rd_item_t rd_q[$];
    px_item_t px_q[$];
    int       fd_q[$];
    mstate_t  m_state = M_IDLE;
    int       mh = 0;
    int       mv = 0;
    logic     m_err = 1'b0;
    int       held0 = 0;
    int       held1 = 0;
    int       checks = 0;
    int       failures = 0;
    vec_t     vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rd_en0"}, mem_rd_en0, 0);
        check({tag, "_rd_en1"}, mem_rd_en1, 0);
        check({tag, "_addr0"}, mem_addr0, 0);
        check({tag, "_addr1"}, mem_addr1, 0);
        check({tag, "_valid0"}, pixel_valid0, 0);
        check({tag, "_valid1"}, pixel_valid1, 0);
        check({tag, "_data0"}, pixel_data0, BLANK0);
        check({tag, "_data1"}, pixel_data1, BLANK1);
        check({tag, "_done0"}, frame_done0, 0);
        check({tag, "_done1"}, frame_done1, 0);
        check({tag, "_err0"}, sync_err0, 0);
        check({tag, "_err1"}, sync_err1, 0);
    endtask

    task automatic check_output();
        rd_item_t r;
        px_item_t p;
        if (rd_q.size() > 0 && rd_q[0].e == cyc) begin
            r = rd_q.pop_front();
            check("rd_en0", mem_rd_en0, 1);
            check("rd_en1", mem_rd_en1, 1);
            check("addr0", mem_addr0, r.a0);
            check("addr1", mem_addr1, r.a1);
            held0 = r.a0;
            held1 = r.a1;
        end else begin
            check("idle_rd_en0", mem_rd_en0, 0);
            check("idle_rd_en1", mem_rd_en1, 0);
            check("hold_addr0", mem_addr0, held0);
            check("hold_addr1", mem_addr1, held1);
        end
        if (px_q.size() > 0 && px_q[0].e == cyc) begin
            p = px_q.pop_front();
            check("valid0", pixel_valid0, 1);
            check("valid1", pixel_valid1, 1);
            check("pixel0", pixel_data0, p.p0);
            check("pixel1", pixel_data1, p.p1);
        end else begin
            check("blank_valid0", pixel_valid0, 0);
            check("blank_valid1", pixel_valid1, 0);
            check("blank_pixel0", pixel_data0, BLANK0);
            check("blank_pixel1", pixel_data1, BLANK1);
        end
        if (fd_q.size() > 0 && fd_q[0] == cyc) begin
            void'(fd_q.pop_front());
            check("frame_done0", frame_done0, 1);
            check("frame_done1", frame_done1, 1);
        end else begin
            check("no_frame_done0", frame_done0, 0);
            check("no_frame_done1", frame_done1, 0);
        end
        check("sync_err0", sync_err0, m_err);
        check("sync_err1", sync_err1, m_err);
    endtask

    // Drives one cycle, updates the raster model, then checks on the following falling edge.
    task automatic apply_stimulus(input logic fs, input logic von, input logic clr);
        int  e;
        int  a0;
        int  a1;
        bit  evt;
        e   = cyc + 1;
        evt = 0;
        frame_start = fs;
        video_on    = von;
        err_clear   = clr;
        if (fs) begin
            if (m_state == M_ACTIVE && (mh != 0 || mv != 0)) evt = 1;
            mh = 0;
            mv = 0;
            m_state = M_ACTIVE;
        end
        if (von) begin
            if (m_state == M_ACTIVE) begin
                a0 = mv * 8 + mh;
                a1 = (mv >> 1) * 4 + (mh >> 1);
                rd_q.push_back('{e, a0, a1});
                px_q.push_back('{e + 2, ram_word(a0), ram_word(a1)});
                if (mh == 7 && mv == 3) begin
                    fd_q.push_back(e);
                    mh = 0;
                    mv = 0;
                    m_state = M_DONE;
                end else if (mh == 7) begin
                    mh = 0;
                    mv++;
                end else begin
                    mh++;
                end
            end else if (m_state == M_DONE) begin
                evt = 1;
            end
        end
        if (evt) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_output();
        frame_start = 1'b0;
        video_on    = 1'b0;
        err_clear   = 1'b0;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4; i++) apply_stimulus(0, 0, 0);
        check({tag, "_rd_left"}, rd_q.size(), 0);
        check({tag, "_px_left"}, px_q.size(), 0);
        check({tag, "_fd_left"}, fd_q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{0,  1'b1, 1'b0, 1'b0, 1'b0, 31, 7, 1'b0};
        vecs[1]  = '{13, 1'b1, 1'b1, 1'b0, 1'b1, 0,  0, 1'b1};
        vecs[2]  = '{0,  1'b0, 1'b1, 1'b0, 1'b1, 1,  0, 1'b1};
        vecs[3]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 1,  0, 1'b0};
        vecs[4]  = '{0,  1'b1, 1'b0, 1'b1, 1'b0, 1,  0, 1'b1};
        vecs[5]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 1,  0, 1'b0};
        vecs[6]  = '{32, 1'b0, 1'b1, 1'b0, 1'b0, 31, 7, 1'b1};
        vecs[7]  = '{0,  1'b0, 1'b0, 1'b1, 1'b0, 31, 7, 1'b0};
        vecs[8]  = '{0,  1'b1, 1'b1, 1'b0, 1'b1, 0,  0, 1'b0};
        vecs[9]  = '{0,  1'b0, 1'b1, 1'b0, 1'b1, 1,  0, 1'b0};
        vecs[10] = '{0,  1'b0, 1'b1, 1'b0, 1'b1, 2,  1, 1'b0};

        @(negedge clock);
        @(negedge clock);
        check_reset("por");
        reset = 1'b0;

        // video_on before any frame_start is ignored
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0);

        // full contiguous frame
        apply_stimulus(1, 0, 0);
        for (int i = 0; i < 32; i++) apply_stimulus(0, 1, 0);
        drain("frame");

        // gapped frame: one pixel on, two off
        apply_stimulus(1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(0, 1, 0);
            apply_stimulus(0, 0, 0);
            apply_stimulus(0, 0, 0);
        end
        drain("gap");

        // sync error, clear priority and same-cycle frame_start/video_on
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < vecs[i].pre; k++) apply_stimulus(0, 1, 0);
            apply_stimulus(vecs[i].fs, vecs[i].von, vecs[i].clr);
            check($sformatf("vec%0d_rd0", i), mem_rd_en0, vecs[i].exp_rd);
            check($sformatf("vec%0d_rd1", i), mem_rd_en1, vecs[i].exp_rd);
            check($sformatf("vec%0d_addr0", i), mem_addr0, vecs[i].exp_a0);
            check($sformatf("vec%0d_addr1", i), mem_addr1, vecs[i].exp_a1);
            check($sformatf("vec%0d_err0", i), sync_err0, vecs[i].exp_err);
            check($sformatf("vec%0d_err1", i), sync_err1, vecs[i].exp_err);
        end
        drain("vec");

        // reset in the middle of line 2 with reads in flight
        apply_stimulus(1, 0, 0);
        for (int i = 0; i < 19; i++) apply_stimulus(0, 1, 0);
        #2 reset = 1'b1;
        #1 check_reset("mid");
        rd_q.delete();
        px_q.delete();
        fd_q.delete();
        m_state = M_IDLE;
        mh = 0;
        mv = 0;
        m_err = 1'b0;
        held0 = 0;
        held1 = 0;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) apply_stimulus(0, 1, 0);
        apply_stimulus(1, 1, 0);
        check("restart_addr0", mem_addr0, 0);
        check("restart_rd0", mem_rd_en0, 1);
        apply_stimulus(0, 1, 0);
        apply_stimulus(0, 1, 0);
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
